rv_iopmp_entry_scan_ctrl: RTL and testbench

Sequential matching controller for the IOPMP checker. It accepts one transaction at a time and scans the entry table range assigned to the requesting memory domain, one entry per cycle, through a single internal rv_iopmp_entry_analyzer instance. It resolves the result by priority: the lowest-indexed hit wins. It returns an allow/deny response with the hit entry index and an error cause. It sits between the transaction front-end (SRCMD/MDCFG lookup) and the entry register file.

---
 rtl/rv_iopmp_entry_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_rv_iopmp_entry_scan_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_entry_scan_ctrl.sv
// IOPMP sequential entry scanner: walks the MD entry range one entry per cycle
// and reports the lowest-indexed hit as an allow/deny response.
module rv_iopmp_entry_scan_ctrl #(
  parameter int NUM_ENTRY  = 16,
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  localparam int IDX_W = $clog2(NUM_ENTRY),
  localparam int BND_W = IDX_W + 1,
  localparam int NB_W  = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NB_W-1:0]       req_num_bytes_i,
  input  logic [2:0]            req_type_i,
  input  logic [BND_W-1:0]      req_entry_lo_i,
  input  logic [BND_W-1:0]      req_entry_hi_i,
  output logic [IDX_W-1:0]      entry_idx_o,
  input  logic [LEN-1:0]        entry_addr_i,
  input  logic [LEN-1:0]        entry_addrh_i,
  input  logic [1:0]            entry_mode_i,
  input  logic [2:0]            entry_perm_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output logic                  rsp_hit_o,
  output logic [IDX_W-1:0]      rsp_entry_idx_o,
  output logic [1:0]            rsp_err_o
);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NO_MATCH = 2'd1;
  localparam logic [1:0] ERR_PARTIAL  = 2'd2;
  localparam logic [1:0] ERR_PERM     = 2'd3;

  typedef enum logic [1:0] {IDLE, PREV, SCAN, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   final_reg, final_next;
  logic [2:0]              type_reg, type_next;
  logic [BND_W-1:0]        hi_reg, hi_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [2*LEN-1:0]        prev_reg, prev_next;
  logic                    allow_reg, allow_next;
  logic                    hit_reg, hit_next;
  logic [IDX_W-1:0]        rsp_idx_reg, rsp_idx_next;
  logic [1:0]              err_reg, err_next;

  logic [BND_W-1:0]        hi_clamp;
  logic [2*LEN-1:0]        entry_word;
  logic                    an_match, an_partial, an_allow;
  logic                    last_idx;

  assign hi_clamp   = (req_entry_hi_i > BND_W'(NUM_ENTRY)) ? BND_W'(NUM_ENTRY) : req_entry_hi_i;
  assign entry_word = {entry_addrh_i, entry_addr_i};
  assign last_idx   = (BND_W'(idx_reg) == (hi_reg - BND_W'(1)));

  rv_iopmp_entry_analyzer #(
    .LEN        (LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_analyzer (
    .addr_i    (addr_reg),
    .final_i   (final_reg),
    .type_i    (type_reg),
    .prev_i    (prev_reg),
    .entry_i   (entry_word),
    .mode_i    (entry_mode_i),
    .perm_i    (entry_perm_i),
    .match_o   (an_match),
    .partial_o (an_partial),
    .allow_o   (an_allow)
  );

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    final_next   = final_reg;
    type_next    = type_reg;
    hi_next      = hi_reg;
    idx_next     = idx_reg;
    prev_next    = prev_reg;
    allow_next   = allow_reg;
    hit_next     = hit_reg;
    rsp_idx_next = rsp_idx_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          addr_next    = req_addr_i;
          final_next   = req_addr_i + ADDR_WIDTH'(req_num_bytes_i) - ADDR_WIDTH'(1);
          type_next    = req_type_i;
          hi_next      = hi_clamp;
          idx_next     = req_entry_lo_i[IDX_W-1:0];
          prev_next    = '0;
          allow_next   = 1'b0;
          hit_next     = 1'b0;
          rsp_idx_next = '0;
          err_next     = ERR_NONE;
          if (!enable_i) begin
            state_next = RESP;
            allow_next = 1'b1;
          end else if (req_entry_lo_i >= hi_clamp) begin
            state_next = RESP;
            err_next   = ERR_NO_MATCH;
          end else if (req_entry_lo_i != '0) begin
            state_next = PREV;
          end else begin
            state_next = SCAN;
          end
        end
      end
      PREV: begin
        // Entry lo-1 supplies the lower TOR bound for entry lo.
        prev_next  = entry_word;
        state_next = SCAN;
      end
      SCAN: begin
        if (an_match) begin
          state_next   = RESP;
          hit_next     = 1'b1;
          rsp_idx_next = idx_reg;
          allow_next   = an_allow;
          err_next     = an_allow ? ERR_NONE : ERR_PERM;
        end else if (an_partial) begin
          state_next   = RESP;
          hit_next     = 1'b1;
          rsp_idx_next = idx_reg;
          allow_next   = 1'b0;
          err_next     = ERR_PARTIAL;
        end else if (last_idx) begin
          state_next   = RESP;
          allow_next   = 1'b0;
          err_next     = ERR_NO_MATCH;
        end else begin
          idx_next  = idx_reg + IDX_W'(1);
          prev_next = entry_word;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      final_reg   <= '0;
      type_reg    <= '0;
      hi_reg      <= '0;
      idx_reg     <= '0;
      prev_reg    <= '0;
      allow_reg   <= 1'b0;
      hit_reg     <= 1'b0;
      rsp_idx_reg <= '0;
      err_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      final_reg   <= final_next;
      type_reg    <= type_next;
      hi_reg      <= hi_next;
      idx_reg     <= idx_next;
      prev_reg    <= prev_next;
      allow_reg   <= allow_next;
      hit_reg     <= hit_next;
      rsp_idx_reg <= rsp_idx_next;
      err_reg     <= err_next;
    end
  end

  assign req_ready_o     = (state_reg == IDLE) && !rst_i;
  assign entry_idx_o     = (state_reg == PREV) ? (idx_reg - IDX_W'(1)) : idx_reg;
  assign rsp_valid_o     = (state_reg == RESP);
  assign rsp_allow_o     = allow_reg;
  assign rsp_hit_o       = hit_reg;
  assign rsp_entry_idx_o = rsp_idx_reg;
  assign rsp_err_o       = err_reg;

endmodule

// Single-entry address/permission checker. Entry addresses are word (>>2)
// encoded; the comparison width leaves headroom so region ends never wrap.
module rv_iopmp_entry_analyzer #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] final_i,
  input  logic [2:0]            type_i,
  input  logic [2*LEN-1:0]      prev_i,
  input  logic [2*LEN-1:0]      entry_i,
  input  logic [1:0]            mode_i,
  input  logic [2:0]            perm_i,
  output logic                  match_o,
  output logic                  partial_o,
  output logic                  allow_o
);

  localparam int EW = 2*LEN;
  localparam int CW = ((EW + 2 > ADDR_WIDTH) ? EW + 2 : ADDR_WIDTH) + 2;

  localparam logic [1:0] MODE_TOR   = 2'd1;
  localparam logic [1:0] MODE_NA4   = 2'd2;
  localparam logic [1:0] MODE_NAPOT = 2'd3;

  logic [CW-1:0] start_c, last_c, word_c, mask_c, base_c, end_c;
  logic          valid_c, inside_c, overlap_c;

  always_comb begin
    start_c = CW'(addr_i);
    last_c  = CW'(final_i);
    word_c  = CW'(entry_i);
    mask_c  = '0;
    base_c  = '0;
    end_c   = '0;
    valid_c = 1'b0;
    case (mode_i)
      MODE_TOR: begin
        base_c  = CW'(prev_i) << 2;
        end_c   = word_c << 2;
        valid_c = (prev_i < entry_i);
      end
      MODE_NA4: begin
        base_c  = word_c << 2;
        end_c   = (word_c << 2) + CW'(4);
        valid_c = 1'b1;
      end
      MODE_NAPOT: begin
        // Trailing ones plus the first zero form the region's word mask.
        mask_c  = word_c ^ (word_c + CW'(1));
        base_c  = (word_c & ~mask_c) << 2;
        end_c   = ((word_c & ~mask_c) + mask_c + CW'(1)) << 2;
        valid_c = 1'b1;
      end
      default: valid_c = 1'b0;
    endcase
    inside_c  = valid_c && (start_c >= base_c) && (last_c < end_c);
    overlap_c = valid_c && (start_c < end_c) && (last_c >= base_c);
  end

  assign match_o   = inside_c;
  assign partial_o = overlap_c && !inside_c;
  assign allow_o   = inside_c && ((type_i & ~perm_i) == 3'b000);

endmodule

// File: tb/tb_rv_iopmp_entry_scan_ctrl.sv
// Self-checking bench for rv_iopmp_entry_scan_ctrl: directed scenarios plus
// randomized transactions against a range-based reference model.
module tb_rv_iopmp_entry_scan_ctrl;

  localparam int NE = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = '0;
  logic [3:0]  req_num_bytes_i = '0;
  logic [2:0]  req_type_i = '0;
  logic [4:0]  req_entry_lo_i = '0;
  logic [4:0]  req_entry_hi_i = '0;
  logic [3:0]  entry_idx_o;
  logic [31:0] entry_addr_i, entry_addrh_i;
  logic [1:0]  entry_mode_i;
  logic [2:0]  entry_perm_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_allow_o, rsp_hit_o;
  logic [3:0]  rsp_entry_idx_o;
  logic [1:0]  rsp_err_o;

  logic [31:0] tbl_addr [NE];
  logic [31:0] tbl_addrh[NE];
  logic [1:0]  tbl_mode [NE];
  logic [2:0]  tbl_perm [NE];

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] AR = 3'b001, AW = 3'b010, AX = 3'b100;
  localparam logic [1:0] M_OFF = 2'd0, M_TOR = 2'd1, M_NA4 = 2'd2, M_NAPOT = 2'd3;

  assign entry_addr_i  = tbl_addr[entry_idx_o];
  assign entry_addrh_i = tbl_addrh[entry_idx_o];
  assign entry_mode_i  = tbl_mode[entry_idx_o];
  assign entry_perm_i  = tbl_perm[entry_idx_o];

  always #5 clk = ~clk;

  rv_iopmp_entry_scan_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_num_bytes_i (req_num_bytes_i),
    .req_type_i      (req_type_i),
    .req_entry_lo_i  (req_entry_lo_i),
    .req_entry_hi_i  (req_entry_hi_i),
    .entry_idx_o     (entry_idx_o),
    .entry_addr_i    (entry_addr_i),
    .entry_addrh_i   (entry_addrh_i),
    .entry_mode_i    (entry_mode_i),
    .entry_perm_i    (entry_perm_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_allow_o     (rsp_allow_o),
    .rsp_hit_o       (rsp_hit_o),
    .rsp_entry_idx_o (rsp_entry_idx_o),
    .rsp_err_o       (rsp_err_o)
  );

  // Result vector layout: {allow, hit, idx[3:0], err[1:0], latency[7:0]}
  function automatic logic [15:0] model(input logic [63:0] a, input int nb, input logic [2:0] t,
                                        input int lo, input int hi_raw, input logic en);
    logic [127:0] first, last, b, e, cur, prv, sz;
    int hi, extra, ones;
    bit has, ok;
    hi = (hi_raw > NE) ? NE : hi_raw;
    if (!en) return {1'b1, 1'b0, 4'd0, 2'd0, 8'd1};
    if (lo >= hi) return {1'b0, 1'b0, 4'd0, 2'd1, 8'd1};
    extra = (lo > 0) ? 1 : 0;
    first = 128'(a);
    last  = 128'(a) + 128'(nb) - 128'd1;
    for (int i = lo; i < hi; i++) begin
      cur = 128'({tbl_addrh[i], tbl_addr[i]});
      has = 1'b1;
      b = '0;
      e = '0;
      case (tbl_mode[i])
        M_TOR: begin
          prv = (i == 0) ? 128'd0 : 128'({tbl_addrh[i-1], tbl_addr[i-1]});
          b = prv * 4;
          e = cur * 4;
          has = (b < e);
        end
        M_NA4: begin
          b = cur * 4;
          e = b + 4;
        end
        M_NAPOT: begin
          ones = 0;
          while (ones < 64 && cur[ones]) ones++;
          sz = 128'd8 << ones;
          b = (cur * 4) & ~(sz - 128'd1);
          e = b + sz;
        end
        default: has = 1'b0;
      endcase
      if (has && first >= b && last < e) begin
        ok = ((t & ~tbl_perm[i]) == 3'b000);
        return {ok, 1'b1, 4'(i), ok ? 2'd0 : 2'd3, 8'(1 + extra + i - lo + 1)};
      end
      if (has && first < e && last >= b)
        return {1'b0, 1'b1, 4'(i), 2'd2, 8'(1 + extra + i - lo + 1)};
    end
    return {1'b0, 1'b0, 4'd0, 2'd1, 8'(1 + extra + hi - lo)};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < NE; i++) begin
      tbl_addr[i]  = '0;
      tbl_addrh[i] = '0;
      tbl_mode[i]  = M_OFF;
      tbl_perm[i]  = '0;
    end
  endtask

  // Drives one request and collects the response; comparisons are left to the caller.
  task automatic drive(input logic [63:0] a, input int nb, input logic [2:0] t, input int lo,
                       input int hi, input logic en, input int hold,
                       output logic [15:0] res, output logic [3:0] first_idx,
                       output bit stable, output bit hs);
    int lat;
    logic [7:0] snap;
    @(negedge clk);
    req_addr_i      = a;
    req_num_bytes_i = 4'(nb);
    req_type_i      = t;
    req_entry_lo_i  = 5'(lo);
    req_entry_hi_i  = 5'(hi);
    enable_i        = en;
    req_valid_i     = 1'b1;
    hs = (req_ready_o === 1'b1);
    @(posedge clk);
    #1;
    req_valid_i     = 1'b0;
    req_addr_i      = {$urandom, $urandom};
    req_num_bytes_i = 4'($urandom);
    req_type_i      = 3'($urandom);
    req_entry_lo_i  = 5'($urandom);
    req_entry_hi_i  = 5'($urandom);
    enable_i        = 1'($urandom);
    first_idx = entry_idx_o;
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (rsp_valid_o !== 1'b1) lat = 255;
    res = {rsp_allow_o, rsp_hit_o, rsp_entry_idx_o, rsp_err_o, 8'(lat)};
    snap = {rsp_allow_o, rsp_hit_o, rsp_entry_idx_o, rsp_err_o};
    stable = 1'b1;
    if (req_ready_o !== 1'b0) hs = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
          {rsp_allow_o, rsp_hit_o, rsp_entry_idx_o, rsp_err_o} !== snap) stable = 1'b0;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) hs = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {req_ready_o, rsp_valid_o, rsp_allow_o, rsp_hit_o, rsp_entry_idx_o, rsp_err_o, entry_idx_o};
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h need 0000", obs);
    end
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: ready/valid got %b need 10", {req_ready_o, rsp_valid_o});
    end
    $display("test_reset done");
  endtask

  task automatic test_disabled();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    drive(64'h1234, 4, AW, 0, 16, 1'b0, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b1, 1'b0, 4'd0, 2'd0, 8'd1} || !hs) begin
      errors++;
      $display("FAIL disabled: got %h hs=%0d need %h hs=1", res, hs, {1'b1, 1'b0, 4'd0, 2'd0, 8'd1});
    end
    $display("txn disabled res=%h", res);
  endtask

  task automatic test_napot();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    tbl_addr[0] = 32'h2000_01FF; tbl_mode[0] = M_NAPOT; tbl_perm[0] = AR;
    drive(64'h8000_0100, 8, AR, 0, 4, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b1, 1'b1, 4'd0, 2'd0, 8'd2} || !hs) begin
      errors++;
      $display("FAIL napot_read: got %h hs=%0d need %h", res, hs, {1'b1, 1'b1, 4'd0, 2'd0, 8'd2});
    end
    $display("txn napot res=%h", res);
  endtask

  task automatic test_tor_prev();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    tbl_addr[1] = 32'h1000;
    tbl_addr[2] = 32'h2000; tbl_mode[2] = M_TOR; tbl_perm[2] = AR | AW;
    drive(64'h5000, 8, AW, 2, 4, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b1, 1'b1, 4'd2, 2'd0, 8'd3}) begin
      errors++;
      $display("FAIL tor_match: got %h need %h", res, {1'b1, 1'b1, 4'd2, 2'd0, 8'd3});
    end
    checks++;
    if (fi !== 4'd1) begin
      errors++;
      $display("FAIL tor_prev_idx: got %0d need 1", fi);
    end
    $display("txn tor res=%h prev_idx=%0d", res, fi);
  endtask

  task automatic test_partial_priority();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    tbl_addr[0] = 32'h40;  tbl_mode[0] = M_NA4;   tbl_perm[0] = AR | AW;
    tbl_addr[1] = 32'h1FF; tbl_mode[1] = M_NAPOT; tbl_perm[1] = AR | AW | AX;
    drive(64'h100, 8, AR, 0, 4, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b1, 4'd0, 2'd2, 8'd2}) begin
      errors++;
      $display("FAIL partial: got %h need %h", res, {1'b0, 1'b1, 4'd0, 2'd2, 8'd2});
    end
    $display("txn partial res=%h", res);
  endtask

  task automatic test_perm();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    tbl_addr[3] = 32'h10; tbl_mode[3] = M_NA4; tbl_perm[3] = AR;
    drive(64'h40, 4, AW, 0, 8, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b1, 4'd3, 2'd3, 8'd5}) begin
      errors++;
      $display("FAIL perm: got %h need %h", res, {1'b0, 1'b1, 4'd3, 2'd3, 8'd5});
    end
    $display("txn perm res=%h", res);
  endtask

  task automatic test_no_match_hold();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    drive(64'h40, 4, AR, 0, 16, 1'b1, 5, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b0, 4'd0, 2'd1, 8'd17}) begin
      errors++;
      $display("FAIL no_match: got %h need %h", res, {1'b0, 1'b0, 4'd0, 2'd1, 8'd17});
    end
    checks++;
    if (!st || !hs) begin
      errors++;
      $display("FAIL hold_stable: stable=%0d hs=%0d need 1 1", st, hs);
    end
    $display("txn no_match res=%h", res);
  endtask

  task automatic test_range_bounds();
    logic [15:0] res; logic [3:0] fi; bit st, hs;
    clear_table();
    drive(64'h40, 4, AR, 5, 5, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b0, 4'd0, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL empty_range: got %h need %h", res, {1'b0, 1'b0, 4'd0, 2'd1, 8'd1});
    end
    drive(64'h40, 4, AR, 0, 31, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b0, 4'd0, 2'd1, 8'd17}) begin
      errors++;
      $display("FAIL hi_clamp: got %h need %h", res, {1'b0, 1'b0, 4'd0, 2'd1, 8'd17});
    end
    drive(64'h40, 4, AR, 16, 20, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b0, 1'b0, 4'd0, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL lo_past_end: got %h need %h", res, {1'b0, 1'b0, 4'd0, 2'd1, 8'd1});
    end
    tbl_addr[15] = 32'h10; tbl_mode[15] = M_NA4; tbl_perm[15] = AX;
    drive(64'h40, 4, AX, 15, 16, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b1, 1'b1, 4'd15, 2'd0, 8'd3}) begin
      errors++;
      $display("FAIL last_entry: got %h need %h", res, {1'b1, 1'b1, 4'd15, 2'd0, 8'd3});
    end
    $display("txn bounds last_res=%h", res);
  endtask

  task automatic test_abort();
    logic [15:0] res; logic [3:0] fi; bit st, hs, seen;
    clear_table();
    @(negedge clk);
    req_addr_i = 64'h40; req_num_bytes_i = 4'd4; req_type_i = AR;
    req_entry_lo_i = 5'd0; req_entry_hi_i = 5'd16; enable_i = 1'b1; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL abort_in_reset: ready/valid got %b need 00", {req_ready_o, rsp_valid_o});
    end
    rst_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_rsp: stray response or not ready after abort");
    end
    tbl_addr[0] = 32'h10; tbl_mode[0] = M_NA4; tbl_perm[0] = AR;
    drive(64'h40, 4, AR, 0, 16, 1'b1, 0, res, fi, st, hs);
    checks++;
    if (res !== {1'b1, 1'b1, 4'd0, 2'd0, 8'd2}) begin
      errors++;
      $display("FAIL abort_recover: got %h need %h", res, {1'b1, 1'b1, 4'd0, 2'd0, 8'd2});
    end
    $display("txn abort_recover res=%h", res);
  endtask

  task automatic test_back_to_back();
    logic [15:0] r1, r2; logic [3:0] fi; bit st, h1, h2;
    clear_table();
    tbl_addr[0] = 32'h1FF; tbl_mode[0] = M_NAPOT; tbl_perm[0] = AR;
    drive(64'h10, 2, AR, 0, 2, 1'b1, 0, r1, fi, st, h1);
    drive(64'h10, 2, AW, 0, 2, 1'b1, 0, r2, fi, st, h2);
    checks++;
    if ({r1, r2} !== {1'b1, 1'b1, 4'd0, 2'd0, 8'd2, 1'b0, 1'b1, 4'd0, 2'd3, 8'd2} || !h1 || !h2) begin
      errors++;
      $display("FAIL back_to_back: got %h %h hs=%0d%0d", r1, r2, h1, h2);
    end
    $display("txn back_to_back res=%h %h", r1, r2);
  endtask

  task automatic test_random();
    logic [15:0] res, exp; logic [3:0] fi; bit st, hs;
    logic [63:0] a; logic [2:0] t; int nb, lo, hi, hold; logic en;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NE; i++) begin
        tbl_addr[i]  = $urandom_range(0, 32'h180);
        tbl_addrh[i] = '0;
        tbl_mode[i]  = 2'($urandom);
        tbl_perm[i]  = 3'($urandom);
      end
      a  = 64'($urandom_range(0, 32'h600));
      nb = $urandom_range(1, 8);
      t  = 3'b001 << $urandom_range(0, 2);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0) begin
        lo = $urandom_range(0, 12);
        hi = lo + $urandom_range(1, 8);
      end else begin
        lo = $urandom_range(0, 17);
        hi = $urandom_range(0, 31);
      end
      hold = $urandom_range(0, 3);
      exp = model(a, nb, t, lo, hi, en);
      drive(a, nb, t, lo, hi, en, hold, res, fi, st, hs);
      checks++;
      if (res !== exp || !st || !hs) begin
        errors++;
        $display("FAIL random_%0d: addr=%h nb=%0d t=%b lo=%0d hi=%0d en=%0d got %h st=%0d hs=%0d need %h",
                 n, a, nb, t, lo, hi, en, res, st, hs, exp);
      end
      $display("txn random_%0d addr=%h lo=%0d hi=%0d res=%h", n, a, lo, hi, res);
    end
  endtask

  initial begin
    clear_table();
    test_reset();
    test_disabled();
    test_napot();
    test_tor_prev();
    test_partial_priority();
    test_perm();
    test_no_match_hold();
    test_range_bounds();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
